// File: rtl/ddr_tx_serializer.sv
// HDR-DDR transmit serializer: launches preambles, words, parity, CRC token and CRC5 on SDA,
// one bit per SCL edge. Define DDR_TX_CRC_EN to build the CRC5 register; otherwise o_crc is tied to CRC_SEED.
module ddr_tx_serializer #(
   parameter int         WORD_W   = 16,
   parameter logic [4:0] CRC_SEED = 5'b11111
) (
   input  logic              i_sys_clk,
   input  logic              i_sys_rst,
   input  logic              i_scl_pos_edge,
   input  logic              i_scl_neg_edge,
   input  logic              i_tx_en,
   input  logic [3:0]        i_tx_mode,
   input  logic [WORD_W-1:0] i_tx_word,
   output logic              o_sda,
   output logic              o_tx_mode_done,
   output logic              o_tx_busy,
   output logic [4:0]        o_crc,
   output logic              o_tx_illegal
);

   localparam int LEN_W = $clog2(WORD_W + 1);

   localparam logic [3:0] M_IDLE      = 4'd0;
   localparam logic [3:0] M_PRE_CMD   = 4'd1;
   localparam logic [3:0] M_PRE_DATA  = 4'd2;
   localparam logic [3:0] M_ZERO      = 4'd3;
   localparam logic [3:0] M_ONE       = 4'd4;
   localparam logic [3:0] M_CMD_WORD  = 4'd5;
   localparam logic [3:0] M_DATA_WORD = 4'd6;
   localparam logic [3:0] M_PARITY    = 4'd7;
   localparam logic [3:0] M_CRC_TOKEN = 4'd8;
   localparam logic [3:0] M_CRC_VALUE = 4'd9;

   typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

   state_t             state;
   logic [WORD_W-1:0]  shreg;
   logic [LEN_W-1:0]   bits_left;
   logic [WORD_W-1:0]  word_q;
   logic               sda_q;
   logic               done_q;
   logic               busy_q;
   logic               illegal_q;

   logic               scl_edge;
   logic               start_fld;
   logic               shift_bit;
   logic               launch_bit;
   logic [WORD_W-1:0]  ld_bits;
   logic [LEN_W-1:0]   ld_len;
   logic               ld_illegal;
   logic               pa1;
   logic               pa0;
   logic [4:0]         crc_tx;

   assign scl_edge  = i_scl_pos_edge | i_scl_neg_edge;
   // A new field starts from IDLE, or right after the previous field's last bit (bits_left == 0).
   assign start_fld = scl_edge & i_tx_en & ((state == ST_IDLE) | (bits_left == '0));
   assign shift_bit = scl_edge & i_tx_en & (state == ST_SHIFT) & (bits_left != '0);
   assign launch_bit = start_fld ? ld_bits[WORD_W-1] : shreg[WORD_W-1];

   always_comb begin
      pa1 = 1'b0;
      pa0 = 1'b1;
      for (int i = 0; i < WORD_W; i++) begin
         if (i % 2 == 1) pa1 = pa1 ^ word_q[i];
         else            pa0 = pa0 ^ word_q[i];
      end
   end

   // Field image, left-aligned so the MSB is always the next bit out.
   always_comb begin
      ld_bits    = '0;
      ld_len     = LEN_W'(1);
      ld_illegal = 1'b0;
      case (i_tx_mode)
         M_IDLE:      ld_bits[WORD_W-1] = 1'b1;
         M_PRE_CMD:   begin ld_bits[WORD_W-1 -: 2] = 2'b01; ld_len = LEN_W'(2); end
         M_PRE_DATA:  begin ld_bits[WORD_W-1 -: 2] = 2'b11; ld_len = LEN_W'(2); end
         M_ZERO:      ld_bits[WORD_W-1] = 1'b0;
         M_ONE:       ld_bits[WORD_W-1] = 1'b1;
         M_CMD_WORD,
         M_DATA_WORD: begin ld_bits = i_tx_word; ld_len = LEN_W'(WORD_W); end
         M_PARITY:    begin ld_bits[WORD_W-1 -: 2] = {pa1, pa0}; ld_len = LEN_W'(2); end
         M_CRC_TOKEN: begin ld_bits[WORD_W-1 -: 4] = 4'b1100; ld_len = LEN_W'(4); end
         M_CRC_VALUE: begin ld_bits[WORD_W-1 -: 5] = crc_tx; ld_len = LEN_W'(5); end
         default:     begin ld_bits[WORD_W-1] = 1'b1; ld_illegal = 1'b1; end
      endcase
   end

   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) begin
         state     <= ST_IDLE;
         shreg     <= '0;
         bits_left <= '0;
         word_q    <= '0;
         sda_q     <= 1'b1;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start_fld) begin
            state <= ST_SHIFT;
            if (i_tx_mode == M_CMD_WORD || i_tx_mode == M_DATA_WORD) word_q <= i_tx_word;
            shreg     <= ld_bits << 1;
            bits_left <= ld_len - LEN_W'(1);
            sda_q     <= launch_bit;
            done_q    <= (ld_len == LEN_W'(1));
            busy_q    <= 1'b1;
            if (ld_illegal) illegal_q <= 1'b1;
         end else if (shift_bit) begin
            shreg     <= shreg << 1;
            bits_left <= bits_left - LEN_W'(1);
            sda_q     <= launch_bit;
            done_q    <= (bits_left == LEN_W'(1));
         end else if (scl_edge && state == ST_SHIFT) begin
            // Enable dropped: either a clean end after done or a mid-field abort.
            state     <= ST_IDLE;
            bits_left <= '0;
            sda_q     <= 1'b1;
            busy_q    <= 1'b0;
         end
      end
   end

`ifdef DDR_TX_CRC_EN
   logic [4:0] crc_q;
   logic       data_fld;

   function automatic logic [4:0] crc_next(input logic [4:0] c, input logic d);
      logic fb;
      fb = c[4] ^ d;
      return {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
   endfunction

   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) begin
         crc_q    <= CRC_SEED;
         data_fld <= 1'b0;
      end else if (start_fld) begin
         data_fld <= (i_tx_mode == M_DATA_WORD);
         if (i_tx_mode == M_PRE_CMD)        crc_q <= CRC_SEED;
         else if (i_tx_mode == M_DATA_WORD) crc_q <= crc_next(crc_q, launch_bit);
      end else if (shift_bit && data_fld) begin
         crc_q <= crc_next(crc_q, launch_bit);
      end
   end

   assign crc_tx = crc_q;
   assign o_crc  = crc_q;
`else
   assign crc_tx = 5'b11111;
   assign o_crc  = CRC_SEED;
`endif

   assign o_sda          = sda_q;
   assign o_tx_mode_done = done_q;
   assign o_tx_busy      = busy_q;
   assign o_tx_illegal   = illegal_q;

endmodule

// File: tb/tb_ddr_tx_serializer.sv
// Bench for ddr_tx_serializer: field table plus hand sequences for back-to-back, CRC, abort,
// illegal mode and mid-field reset. Honours DDR_TX_CRC_EN the same way as the design.
module tb_ddr_tx_serializer;

   logic        clk = 1'b0;
   logic        rst;
   logic        pos_edge;
   logic        neg_edge;
   logic        tx_en;
   logic [3:0]  tx_mode;
   logic [15:0] tx_word;
   logic        sda;
   logic        done;
   logic        busy;
   logic [4:0]  crc;
   logic        illegal;

   int checks = 0;
   int errors = 0;

   // Each entry is {sda bit, done expected on that edge}.
   logic [1:0] exp_q[$];

   typedef struct {
      logic [3:0]  mode;
      logic [15:0] word;
      int          len;
      logic [15:0] bits;
   } vec_t;

   vec_t vecs[10];

   always #10 clk = ~clk;

   ddr_tx_serializer #(.WORD_W(16), .CRC_SEED(5'b11111)) dut (
      .i_sys_clk      (clk),
      .i_sys_rst      (rst),
      .i_scl_pos_edge (pos_edge),
      .i_scl_neg_edge (neg_edge),
      .i_tx_en        (tx_en),
      .i_tx_mode      (tx_mode),
      .i_tx_word      (tx_word),
      .o_sda          (sda),
      .o_tx_mode_done (done),
      .o_tx_busy      (busy),
      .o_crc          (crc),
      .o_tx_illegal   (illegal)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] model_crc(input logic [4:0] seed, input logic [15:0] w, input int n);
      logic [4:0] c;
      logic       fb;
      c = seed;
      for (int i = 0; i < n; i++) begin
         fb = c[4] ^ w[15-i];
         c  = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
      end
      return c;
   endfunction

   // One SCL edge: strobe for one clock, outputs are sampled on the following falling clock edge.
   task automatic scl_edge();
      int kind;
      @(negedge clk);
      kind     = $urandom_range(0, 2);
      pos_edge = (kind != 1);
      neg_edge = (kind != 0);
      @(negedge clk);
      pos_edge = 1'b0;
      neg_edge = 1'b0;
   endtask

   task automatic push_field(input logic [15:0] bits, input int len);
      for (int i = 0; i < len; i++) exp_q.push_back({bits[len-1-i], (i == len - 1)});
   endtask

   task automatic check_bit();
      logic [1:0] e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_underflow: got empty queue, expected an entry");
      end else begin
         e = exp_q.pop_front();
         check("sda_bit", sda, e[1]);
         check("done_on_bit", done, e[0]);
         check("busy_in_field", busy, 1'b1);
      end
      @(negedge clk);
      check("done_one_cycle", done, 1'b0);
   endtask

   task automatic run_field(input logic [3:0] mode, input logic [15:0] word, input int len, input bit stop);
      tx_en   = 1'b1;
      tx_mode = mode;
      tx_word = word;
      for (int i = 0; i < len; i++) begin
         scl_edge();
         if (i == 0) begin
            tx_mode = 4'($urandom_range(0, 15));
            tx_word = 16'($urandom);
         end
         check_bit();
      end
      if (stop) begin
         tx_en = 1'b0;
         scl_edge();
         check("idle_sda", sda, 1'b1);
         check("idle_done", done, 1'b0);
         check("idle_busy", busy, 1'b0);
      end
   endtask

   initial begin
      logic [15:0] w;
      logic [4:0]  exp_crc;

      vecs[0] = '{4'd0, 16'h0000, 1,  16'h0001};
      vecs[1] = '{4'd1, 16'h0000, 2,  16'h0001};
      vecs[2] = '{4'd2, 16'h0000, 2,  16'h0003};
      vecs[3] = '{4'd3, 16'h0000, 1,  16'h0000};
      vecs[4] = '{4'd4, 16'h0000, 1,  16'h0001};
      vecs[5] = '{4'd5, 16'h1234, 16, 16'h1234};
      vecs[6] = '{4'd7, 16'h0000, 2,  16'h0000};
      vecs[7] = '{4'd6, 16'h8000, 16, 16'h8000};
      vecs[8] = '{4'd7, 16'h0000, 2,  16'h0003};
      vecs[9] = '{4'd8, 16'h0000, 4,  16'h000C};

      rst      = 1'b1;
      pos_edge = 1'b0;
      neg_edge = 1'b0;
      tx_en    = 1'b0;
      tx_mode  = 4'd0;
      tx_word  = 16'h0000;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_sda", sda, 1'b1);
      check("rst_done", done, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_crc", crc, 5'b11111);
      check("rst_illegal", illegal, 1'b0);

      scl_edge();
      check("idle_no_en_sda", sda, 1'b1);
      check("idle_no_en_busy", busy, 1'b0);

      for (int v = 0; v < 10; v++) begin
         push_field(vecs[v].bits, vecs[v].len);
         run_field(vecs[v].mode, vecs[v].word, vecs[v].len, 1'b1);
         check("legal_no_illegal", illegal, 1'b0);
      end

      // Command word followed immediately by its parity.
      push_field(16'hA5A5, 16);
      push_field(16'h0001, 2);
      run_field(4'd5, 16'hA5A5, 16, 1'b0);
      run_field(4'd7, 16'h0000, 2, 1'b1);

      // Full CRC frame, once with an all-zero word and once with a random word.
      for (int k = 0; k < 2; k++) begin
         w = (k == 0) ? 16'h0000 : 16'($urandom);
`ifdef DDR_TX_CRC_EN
         exp_crc = model_crc(5'b11111, w, 16);
`else
         exp_crc = 5'b11111;
`endif
         push_field(16'h0001, 2);
         push_field(w, 16);
         push_field(16'h000C, 4);
         push_field({11'd0, exp_crc}, 5);
         run_field(4'd1, 16'h0000, 2, 1'b0);
         check("crc_after_pre_cmd", crc, 5'b11111);
         run_field(4'd6, w, 16, 1'b0);
         check("crc_after_data", crc, exp_crc);
`ifdef DDR_TX_CRC_EN
         if (k == 0) check("crc_zero_word", crc, 5'b00001);
`endif
         run_field(4'd8, 16'h0000, 4, 1'b0);
         run_field(4'd9, 16'h0000, 5, 1'b1);
      end

      // Abort a data word after seven bits.
      w = 16'($urandom);
      push_field(16'h0001, 2);
      run_field(4'd1, 16'h0000, 2, 1'b0);
      for (int i = 0; i < 7; i++) exp_q.push_back({w[15-i], 1'b0});
      run_field(4'd6, w, 7, 1'b1);
`ifdef DDR_TX_CRC_EN
      check("crc_after_abort", crc, model_crc(5'b11111, w, 7));
`else
      check("crc_after_abort", crc, 5'b11111);
`endif

      // Illegal mode is sticky until reset.
      push_field(16'h0001, 1);
      run_field(4'd12, 16'h0000, 1, 1'b1);
      check("illegal_set", illegal, 1'b1);
      push_field(16'h0001, 1);
      run_field(4'd4, 16'h0000, 1, 1'b1);
      check("illegal_held", illegal, 1'b1);

      // Reset in the middle of a command word.
      w = 16'($urandom);
      for (int i = 0; i < 5; i++) exp_q.push_back({w[15-i], 1'b0});
      run_field(4'd5, w, 5, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_sda", sda, 1'b1);
      check("midrst_busy", busy, 1'b0);
      check("midrst_done", done, 1'b0);
      check("midrst_crc", crc, 5'b11111);
      check("midrst_illegal", illegal, 1'b0);
      push_field(16'h0001, 2);
      run_field(4'd1, 16'h0000, 2, 1'b1);

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
